secondhalf: RTL

//  Consumer end of the first-half completion handshake. Waits for the level flag `start`
//  (driven by firsthalf's index output), then runs the second section:
//  - DRAIN: the 13-LED bar empties one LED per tick while a 2-digit countdown shows on the 7-seg.
//  - CLOCK: an MM:SS clock runs on all four digits.

---
 rtl/secondhalf.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/secondhalf.sv
// Second-section controller: LED bar drain with countdown, then an MM:SS clock, on a 4-digit scan.
// Optional `BLINK_COLON_EN: dp of digit 2 blinks at the tick rate while the clock runs.
module secondhalf #(
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        start,
    output logic [12:0] LED,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        done
);
    // state   | meaning
    // S_IDLE  | waiting for start, outputs dark, scan stopped
    // S_DRAIN | LED bar empties one per tick, 2-digit countdown
    // S_CLOCK | MM:SS clock on all four digits, done high
    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLOCK} state_t;

    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    state_t        state, state_nxt;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx;
    logic [3:0]    rem;
    logic [3:0]    mm_t, mm_o, ss_t, ss_o;
    logic          tick, scan_wrap;
    logic [3:0]    digit;
    logic          blank, dp;
    logic [3:0]    an_nxt;
    logic [7:0]    seg_nxt;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0: seg_code = 7'h40;
            4'd1: seg_code = 7'h79;
            4'd2: seg_code = 7'h24;
            4'd3: seg_code = 7'h30;
            4'd4: seg_code = 7'h19;
            4'd5: seg_code = 7'h12;
            4'd6: seg_code = 7'h02;
            4'd7: seg_code = 7'h78;
            4'd8: seg_code = 7'h00;
            4'd9: seg_code = 7'h10;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        tick      = (state != S_IDLE) && (tick_cnt == TICK_LAST);
        scan_wrap = (state != S_IDLE) && (scan_cnt == SCAN_LAST);
        case (state)
            S_IDLE:  if (start) state_nxt = S_DRAIN;
            S_DRAIN: if (tick && rem == 4'd1) state_nxt = S_CLOCK;
            default: state_nxt = S_CLOCK;
        endcase
    end

    // Digit selection and encoding for the next display register value.
    always_comb begin
        digit = 4'd0;
        blank = 1'b1;
        dp    = 1'b1;
        if (state == S_DRAIN) begin
            case (idx)
                2'd0: begin
                    digit = (rem >= 4'd10) ? 4'(rem - 4'd10) : rem;
                    blank = 1'b0;
                end
                2'd1: begin
                    digit = (rem >= 4'd10) ? 4'd1 : 4'd0;
                    blank = 1'b0;
                end
                default: blank = 1'b1;
            endcase
        end else if (state == S_CLOCK) begin
            blank = 1'b0;
            case (idx)
                2'd0:    digit = ss_o;
                2'd1:    digit = ss_t;
                2'd2:    digit = mm_o;
                default: digit = mm_t;
            endcase
`ifdef BLINK_COLON_EN
            if (idx == 2'd2 && tick_cnt < TW'(TICK_DIV / 2)) dp = 1'b0;
`endif
        end
        an_nxt  = blank ? 4'hF : ~(4'b0001 << idx);
        seg_nxt = blank ? 8'hFF : {dp, seg_code(digit)};
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            scan_cnt <= '0;
            idx      <= 2'd0;
            rem      <= 4'd0;
            mm_t     <= 4'd0;
            mm_o     <= 4'd0;
            ss_t     <= 4'd0;
            ss_o     <= 4'd0;
            LED      <= 13'h0;
            seg      <= 8'hFF;
            an       <= 4'hF;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state_nxt == S_CLOCK);
            if (state == S_IDLE) begin
                tick_cnt <= '0;
                scan_cnt <= '0;
                idx      <= 2'd0;
                seg      <= 8'hFF;
                an       <= 4'hF;
                if (start) begin
                    LED  <= 13'h1FFF;
                    rem  <= 4'd13;
                    mm_t <= 4'd0;
                    mm_o <= 4'd0;
                    ss_t <= 4'd0;
                    ss_o <= 4'd0;
                end
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
                if (scan_wrap) idx <= idx + 2'd1;
                an  <= an_nxt;
                seg <= seg_nxt;
                if (tick && state == S_DRAIN) begin
                    LED <= LED >> 1;
                    rem <= rem - 4'd1;
                end
                if (tick && state == S_CLOCK) begin
                    if (ss_o != 4'd9) ss_o <= ss_o + 4'd1;
                    else begin
                        ss_o <= 4'd0;
                        if (ss_t != 4'd5) ss_t <= ss_t + 4'd1;
                        else begin
                            ss_t <= 4'd0;
                            if (mm_o != 4'd9) mm_o <= mm_o + 4'd1;
                            else begin
                                mm_o <= 4'd0;
                                mm_t <= (mm_t == 4'd5) ? 4'd0 : mm_t + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end
endmodule
